// File: rtl/pfd_loop_pkg.sv
// Shared types and defaults for the ring-oscillator tuning loop controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package pfd_loop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Direction of the most recent ACQUIRE correction, used to spot the first overshoot.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    localparam int DEF_CODE_W   = 6;
    localparam int DEF_WIN_LEN  = 64;
    localparam int DEF_THRESH   = 4;
    localparam int DEF_ACQ_STEP = 4;
    localparam int DEF_LOCK_CNT = 8;

    // Holds +/-WIN_LEN plus a sign bit with one bit of margin.
    function automatic int acc_width(input int win_len);
        return $clog2(win_len) + 2;
    endfunction

endpackage

// File: rtl/pulse_sync2.sv
// Two-flop synchronizer for an asynchronous level/pulse into the clk domain.
// Latency: output follows input after 2 clk edges.
// Backpressure: none.
module pulse_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pfd_loop_ctrl.sv
// Ring-oscillator loop controller: integrates synchronized PFD up/down per window, steps the tune code, flags lock.
// Latency: PFD pulses reach the accumulator 2 cycles late; code/code_valid/locked update one cycle after window end.
// Backpressure: none, free-running; PFD_LOOP_LOL_STICKY_EN adds lol_sticky/lol_clr loss-of-lock history.
module pfd_loop_ctrl
    import pfd_loop_pkg::*;
#(
    parameter int CODE_W   = DEF_CODE_W,
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int THRESH   = DEF_THRESH,
    parameter int ACQ_STEP = DEF_ACQ_STEP,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CODE_W-1:0] code_init,
    input  logic              up,
    input  logic              down,
`ifdef PFD_LOOP_LOL_STICKY_EN
    input  logic              lol_clr,
    output logic              lol_sticky,
`endif
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              locked,
    output logic [1:0]        state
);
    localparam int ACC_W    = acc_width(WIN_LEN);
    localparam int CNT_W    = $clog2(WIN_LEN);
    localparam int QCNT_W   = $clog2(LOCK_CNT + 1);
    localparam int CODE_MAX = (1 << CODE_W) - 1;

    logic up_s;
    logic down_s;

    pulse_sync2 u_sync_up (.clk_i(clk), .rst_n_i(rst_n), .d_i(up),   .q_o(up_s));
    pulse_sync2 u_sync_dn (.clk_i(clk), .rst_n_i(rst_n), .d_i(down), .q_o(down_s));

    state_e                  state_q;
    dir_e                    prev_dir_q;
    logic [CODE_W-1:0]       code_q;
    logic                    code_valid_q;
    logic                    locked_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        win_cnt_q;
    logic [QCNT_W-1:0]       quiet_cnt_q;

    int                      contrib;
    int                      acc_sum;
    logic                    win_end;
    logic                    corr_up;
    logic                    corr_dn;
    logic                    corr;
    logic                    big_err;
    logic                    reversal;
    logic [CODE_W-1:0]       code_fine_d;
    logic [CODE_W-1:0]       code_acq_d;

    function automatic logic [CODE_W-1:0] clamp_code(input int v);
        if (v < 0) return '0;
        if (v > CODE_MAX) return CODE_W'(CODE_MAX);
        return CODE_W'(v);
    endfunction

    // acc_sum includes the current cycle so window-end decisions see the full window.
    always_comb begin
        contrib = 0;
        if (up_s && !down_s) contrib = 1;
        else if (down_s && !up_s) contrib = -1;
        acc_sum     = int'(acc_q) + contrib;
        win_end     = (win_cnt_q == CNT_W'(WIN_LEN - 1));
        corr_up     = (acc_sum > THRESH);
        corr_dn     = (acc_sum < -THRESH);
        corr        = corr_up || corr_dn;
        big_err     = (acc_sum > 2 * THRESH) || (acc_sum < -2 * THRESH);
        reversal    = (corr_up && prev_dir_q == DIR_DN) || (corr_dn && prev_dir_q == DIR_UP);
        code_fine_d = clamp_code(int'(code_q) + (corr_up ? 1 : -1));
        code_acq_d  = clamp_code(int'(code_q) + (corr_up ? ACQ_STEP : -ACQ_STEP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_dir_q   <= DIR_NONE;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            quiet_cnt_q  <= '0;
        end else begin
            code_valid_q <= 1'b0;
            if (!enable) begin
                state_q     <= ST_IDLE;
                prev_dir_q  <= DIR_NONE;
                locked_q    <= 1'b0;
                acc_q       <= '0;
                win_cnt_q   <= '0;
                quiet_cnt_q <= '0;
            end else if (state_q == ST_IDLE) begin
                code_q       <= code_init;
                code_valid_q <= 1'b1;
                state_q      <= ST_ACQUIRE;
            end else begin
                win_cnt_q <= win_cnt_q + CNT_W'(1);
                acc_q     <= win_end ? '0 : ACC_W'(acc_sum);
                if (win_end) begin
                    case (state_q)
                        ST_ACQUIRE: begin
                            if (!corr) begin
                                state_q <= ST_TRACK;
                            end else if (reversal) begin
                                code_q       <= code_fine_d;
                                code_valid_q <= (code_fine_d != code_q);
                                state_q      <= ST_TRACK;
                            end else begin
                                code_q       <= code_acq_d;
                                code_valid_q <= (code_acq_d != code_q);
                            end
                            if (corr) prev_dir_q <= corr_up ? DIR_UP : DIR_DN;
                        end
                        ST_TRACK: begin
                            if (corr) begin
                                code_q       <= code_fine_d;
                                code_valid_q <= (code_fine_d != code_q);
                                quiet_cnt_q  <= '0;
                            end else begin
                                quiet_cnt_q <= quiet_cnt_q + QCNT_W'(1);
                                if (quiet_cnt_q == QCNT_W'(LOCK_CNT - 1)) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (big_err) begin
                                state_q      <= ST_TRACK;
                                locked_q     <= 1'b0;
                                quiet_cnt_q  <= '0;
                                code_q       <= code_fine_d;
                                code_valid_q <= (code_fine_d != code_q);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef PFD_LOOP_LOL_STICKY_EN
    logic lol_sticky_q;
    logic lol_set;

    assign lol_set = enable && (state_q == ST_LOCKED) && win_end && big_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lol_sticky_q <= 1'b0;
        else if (lol_set) lol_sticky_q <= 1'b1;
        else if (lol_clr) lol_sticky_q <= 1'b0;
    end

    assign lol_sticky = lol_sticky_q;
`endif

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign locked     = locked_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pfd_loop_ctrl.sv
// Self-checking bench for pfd_loop_ctrl: window-level reference model, directed scenarios, then random PFD traffic.
`timescale 1ns/1ps
module tb_pfd_loop_ctrl;
    localparam int CODE_W = 6;
    localparam int WIN    = 64;
    localparam int TH     = 4;
    localparam int AS     = 4;
    localparam int LC     = 8;
    localparam int CMAX   = (1 << CODE_W) - 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              enable    = 1'b0;
    logic              up        = 1'b0;
    logic              down      = 1'b0;
    logic [CODE_W-1:0] code_init = '0;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              locked;
    logic [1:0]        state;
`ifdef PFD_LOOP_LOL_STICKY_EN
    logic              lol_clr = 1'b0;
    logic              lol_sticky;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nprint = 0;

    // Reference model state (plain integers).
    int m_code, m_cv, m_lk, m_st, m_acc, m_cnt, m_quiet, m_prev, m_lol;
    int m_um, m_us, m_dm, m_ds;

    always #5 clk = ~clk;

    pfd_loop_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .code_init  (code_init),
        .up         (up),
        .down       (down),
`ifdef PFD_LOOP_LOL_STICKY_EN
        .lol_clr    (lol_clr),
        .lol_sticky (lol_sticky),
`endif
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .state      (state)
    );

    task automatic set_code(input int v);
        int c;
        c = (v < 0) ? 0 : (v > CMAX) ? CMAX : v;
        if (c != m_code) m_cv = 1;
        m_code = c;
    endtask

    // Evaluate one completed window with total phase error e.
    task automatic window_done(input int e);
        int dir;
        dir = (e > TH) ? 1 : (e < -TH) ? -1 : 0;
        case (m_st)
            1: begin
                if (dir == 0) begin
                    m_st = 2;
                end else if (m_prev != 0 && dir != m_prev) begin
                    set_code(m_code + dir);
                    m_st = 2;
                end else begin
                    set_code(m_code + AS * dir);
                end
                if (dir != 0) m_prev = dir;
            end
            2: begin
                if (dir != 0) begin
                    set_code(m_code + dir);
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == LC) begin
                        m_st = 3;
                        m_lk = 1;
                    end
                end
            end
            3: begin
                if (e > 2 * TH || e < -2 * TH) begin
                    m_lk = 0;
                    m_quiet = 0;
                    m_st = 2;
                    set_code(m_code + dir);
                    m_lol = 1;
                end else begin
                    m_lol = m_lol;
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        int us, ds, lol_before;
        cyc++;
        if (!rst_n) begin
            m_code = 0; m_cv = 0; m_lk = 0; m_st = 0; m_acc = 0; m_cnt = 0;
            m_quiet = 0; m_prev = 0; m_lol = 0;
            m_um = 0; m_us = 0; m_dm = 0; m_ds = 0;
        end else begin
            us = m_us; ds = m_ds;
            m_us = m_um; m_ds = m_dm;
            m_um = int'(up); m_dm = int'(down);
            m_cv = 0;
            lol_before = m_lol;
            m_lol = 0;
            if (!enable) begin
                m_st = 0; m_lk = 0; m_acc = 0; m_cnt = 0; m_quiet = 0; m_prev = 0;
            end else if (m_st == 0) begin
                m_code = int'(code_init);
                m_cv = 1;
                m_st = 1;
            end else begin
                m_acc += (us == 1 && ds == 0) ? 1 : (ds == 1 && us == 0) ? -1 : 0;
                if (m_cnt == WIN - 1) begin
                    window_done(m_acc);
                    m_acc = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
`ifdef PFD_LOOP_LOL_STICKY_EN
            if (m_lol == 1) m_lol = 1;
            else if (lol_clr) m_lol = 0;
            else m_lol = lol_before;
`else
            m_lol = lol_before;
`endif
        end
    end

    always @(negedge clk) begin
        bit diff;
        total++;
        diff = (code !== CODE_W'(m_code)) || (code_valid !== 1'(m_cv)) ||
               (locked !== 1'(m_lk)) || (state !== 2'(m_st));
`ifdef PFD_LOOP_LOL_STICKY_EN
        diff = diff || (lol_sticky !== 1'(m_lol));
`endif
        if (diff) begin
            bad++;
            if (nprint < 20) begin
                nprint++;
                $display("FAIL model_cmp cyc=%0d: got code=%0d cv=%0d lk=%0d st=%0d, expected code=%0d cv=%0d lk=%0d st=%0d",
                         cyc, code, code_valid, locked, state, m_code, m_cv, m_lk, m_st);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int probe(input int which);
        case (which)
            0:       return int'(code_valid);
            1:       return int'(locked);
            default: return int'(state);
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input int val, input int maxc);
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (probe(which) == val) return;
        end
        total++;
        bad++;
        $display("FAIL %s: timeout after %0d cycles, got %0d expected %0d", name, maxc, probe(which), val);
    endtask

    initial begin
        int t0, ncv, mode, len;
        repeat (3) @(negedge clk);
        chk("rst_code", int'(code), 0);
        chk("rst_cv", int'(code_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_state", int'(state), 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        code_init = 6'd20; enable = 1'b1; up = 1'b1;
        @(negedge clk);
        chk("enter_code", int'(code), 20);
        chk("enter_cv", int'(code_valid), 1);
        chk("enter_state", int'(state), 1);
        chk("enter_locked", int'(locked), 0);
        @(negedge clk);
        chk("enter_cv_drop", int'(code_valid), 0);

        wait_sig("acq_step_wait", 0, 1, 80);
        chk("acq_step_code", int'(code), 24);
        chk("acq_step_state", int'(state), 1);

        up = 1'b0; down = 1'b1;
        wait_sig("reverse_wait", 2, 2, 80);
        chk("reverse_code", int'(code), 23);
        chk("reverse_cv", int'(code_valid), 1);
        t0 = cyc;

        down = 1'b0;
        wait_sig("lock_wait", 1, 1, 9 * WIN + 20);
        chk("lock_delay", cyc - t0, LC * WIN);
        chk("lock_code", int'(code), 23);
        chk("lock_state", int'(state), 3);

        down = 1'b1;
        wait_sig("lol_wait", 1, 0, 3 * WIN);
        chk("lol_state", int'(state), 2);
        chk("lol_code", int'(code), 22);
        down = 1'b0;
`ifdef PFD_LOOP_LOL_STICKY_EN
        chk("lol_sticky_set", int'(lol_sticky), 1);
        lol_clr = 1'b1;
        @(negedge clk);
        chk("lol_sticky_clr", int'(lol_sticky), 0);
        lol_clr = 1'b0;
`endif

        enable = 1'b0;
        @(negedge clk);
        chk("dis_state", int'(state), 0);
        chk("dis_code_held", int'(code), 22);
        code_init = 6'd61; enable = 1'b1; up = 1'b1;
        @(negedge clk);
        chk("sat_init", int'(code), 61);
        wait_sig("sat_acq_wait", 0, 1, 80);
        chk("sat_acq_clamp", int'(code), 63);
        up = 1'b0; down = 1'b1;
        wait_sig("sat_rev_wait", 2, 2, 80);
        chk("sat_rev_code", int'(code), 62);
        down = 1'b0; up = 1'b1;
        wait_sig("sat_up_wait", 0, 1, 80);
        chk("sat_up_code", int'(code), 63);
        ncv = 0;
        repeat (70) begin
            @(negedge clk);
            if (code_valid) ncv++;
        end
        chk("sat_no_strobe", ncv, 0);
        chk("sat_hold_code", int'(code), 63);
        chk("sat_state", int'(state), 2);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("mid_dis_state", int'(state), 0);
        chk("mid_dis_code", int'(code), 63);
        chk("mid_dis_locked", int'(locked), 0);

        for (int seg = 0; seg < 70; seg++) begin
            mode = $urandom_range(0, 7);
            len  = $urandom_range(20, 700);
            code_init = CODE_W'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0:       begin up = 1'b1; down = 1'b0; end
                    1:       begin up = 1'b0; down = 1'b1; end
                    2, 3:    begin up = 1'b0; down = 1'b0; end
                    4:       begin up = 1'b1; down = 1'b1; end
                    5:       begin up = ($urandom_range(0, 1) == 1); down = ($urandom_range(0, 1) == 1); end
                    6:       begin up = ($urandom_range(0, 9) < 7); down = ($urandom_range(0, 9) < 3); end
                    default: begin up = ($urandom_range(0, 19) == 0); down = ($urandom_range(0, 19) == 0); end
                endcase
`ifdef PFD_LOOP_LOL_STICKY_EN
                lol_clr = ($urandom_range(0, 99) == 0);
`endif
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
